// File: rtl/idx_pkg.sv
// Shared phase constants and sizing helpers for the banked index register file.
package idx_pkg;
   localparam int NIB_DEF = 3;
   localparam int CYC     = NIB_DEF + 5;
   localparam int PH_A1   = 0;
   localparam int PH_M1   = NIB_DEF;
   localparam int PH_M2   = NIB_DEF + 1;

   function automatic int cyc_of(input int nib);
      return nib + 5;
   endfunction

   function automatic int ph_m1(input int nib);
      return nib;
   endfunction

   function automatic int ph_m2(input int nib);
      return nib + 1;
   endfunction

   // Banked registers are replicated, the rest are stored once.
   function automatic int phys_w(input int nreg, input int nbank, input int banked);
      return $clog2(nbank * banked + nreg - banked);
   endfunction
endpackage

// File: rtl/idx_phase_ctr.sv
// Machine-cycle phase counter: sync restarts at phase 0, otherwise wraps at CYC-1.
module idx_phase_ctr #(
   parameter int CYC = 8,
   parameter int PW  = 3
) (
   input  logic          CLK,
   input  logic          RES_N,
   input  logic          sync,
   output logic [PW-1:0] phase
);
   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N)                       phase <= '0;
      else if (sync)                    phase <= '0;
      else if (phase == PW'(CYC - 1))   phase <= '0;
      else                              phase <= phase + 1'b1;
   end
endmodule

// File: rtl/idx_reg_bank.sv
// Banked index register file with address-nibble mux and autonomous FIN fetch/load.
module idx_reg_bank
   import idx_pkg::*;
#(
   parameter int DW     = 4,
   parameter int NREG   = 16,
   parameter int NBANK  = 2,
   parameter int BANKED = 8,
   parameter int ADDR_W = 12,
   localparam int NIB   = ADDR_W / DW,
   localparam int IW    = $clog2(NREG),
   localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1,
   localparam int PW    = $clog2(NIB + 5)
) (
   input  logic              CLK,
   input  logic              RES_N,
   input  logic              sync,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] pc_plus_one,
   input  logic [DW-1:0]     DATA_I,
   input  logic [IW-1:0]     opr_idx,
   input  logic [2*DW-1:0]   imm_pair,
   input  logic              fim,
   input  logic              fin,
   input  logic              wr_alu,
   input  logic              wr_acc,
   input  logic [DW:0]       alu_res,
   input  logic [DW-1:0]     acc,
   input  logic              bank_we,
   input  logic [BW-1:0]     bank_in,
   output logic [DW-1:0]     rn,
   output logic [2*DW-1:0]   rp,
   output logic              rn_zero,
   output logic [DW-1:0]     addr_o,
   output logic              addr_valid,
   output logic [PW-1:0]     phase,
   output logic              fin_busy,
   output logic [BW-1:0]     bank
);
   localparam int NPHYS = NBANK * BANKED + NREG - BANKED;
   localparam int PIW   = phys_w(NREG, NBANK, BANKED);
   localparam logic [PW-1:0] M1 = PW'(ph_m1(NIB));
   localparam logic [PW-1:0] M2 = PW'(ph_m2(NIB));

   logic [NPHYS-1:0][DW-1:0] regs;
   logic                     fin_pend, fin_act;
   logic [BW-1:0]            fin_bank;
   logic [IW-1:0]            fin_dst;
   logic [IW-1:0]            idx_even, idx_odd;
   logic                     fin_ld_even, fin_ld_odd;
   logic                     unused_alu_carry;

   function automatic logic [PIW-1:0] pidx(input logic [IW-1:0] i, input logic [BW-1:0] b);
      if (int'(i) < BANKED) return PIW'(int'(b) * BANKED + int'(i));
      return PIW'(int'(i) + (NBANK - 1) * BANKED);
   endfunction

   idx_phase_ctr #(.CYC(cyc_of(NIB)), .PW(PW)) u_phase (
      .CLK   (CLK),
      .RES_N (RES_N),
      .sync  (sync),
      .phase (phase)
   );

   assign unused_alu_carry = alu_res[DW];
   assign idx_even    = {opr_idx[IW-1:1], 1'b0};
   assign idx_odd     = {opr_idx[IW-1:1], 1'b1};
   assign rn          = regs[pidx(opr_idx, bank)];
   assign rp          = {regs[pidx(idx_even, bank)], regs[pidx(idx_odd, bank)]};
   assign rn_zero     = (rn == '0);
   assign fin_busy    = fin_pend | fin_act;
   assign fin_ld_even = fin_act && (phase == M1);
   assign fin_ld_odd  = fin_act && (phase == M2);

   // During FIN the first two address nibbles come from the latched bank's R1:R0.
   always_comb begin
      addr_o     = '0;
      addr_valid = 1'b0;
      for (int k = 0; k < NIB; k++) begin
         if (phase == PW'(k)) begin
            addr_valid = 1'b1;
            if (!fin_act)    addr_o = pc[k*DW +: DW];
            else if (k == 0) addr_o = regs[pidx(IW'(1), fin_bank)];
            else if (k == 1) addr_o = regs[pidx(IW'(0), fin_bank)];
            else             addr_o = pc_plus_one[k*DW +: DW];
         end
      end
   end

   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         regs <= '0;
      end else if (fim) begin
         regs[pidx(idx_even, bank)] <= imm_pair[2*DW-1:DW];
         regs[pidx(idx_odd, bank)]  <= imm_pair[DW-1:0];
      end else if (fin_ld_even) begin
         regs[pidx(fin_dst, fin_bank)] <= DATA_I;
      end else if (fin_ld_odd) begin
         regs[pidx(fin_dst | IW'(1), fin_bank)] <= DATA_I;
      end else if (wr_alu) begin
         regs[pidx(opr_idx, bank)] <= alu_res[DW-1:0];
      end else if (wr_acc) begin
         regs[pidx(opr_idx, bank)] <= acc;
      end
   end

   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         bank     <= '0;
         fin_pend <= 1'b0;
         fin_act  <= 1'b0;
         fin_bank <= '0;
         fin_dst  <= '0;
      end else begin
         if (bank_we && int'(bank_in) < NBANK) bank <= bank_in;
         if (fin_ld_odd) fin_act <= 1'b0;
         if (sync && fin_pend) begin
            fin_act  <= 1'b1;
            fin_pend <= 1'b0;
         end
         if (fin && !fin_busy) begin
            fin_pend <= 1'b1;
            fin_dst  <= idx_even;
            fin_bank <= bank;
         end
      end
   end
endmodule

// File: tb/tb_idx_reg_bank.sv
// Scoreboard bench: a logical per-bank register model predicts every cycle's outputs.
module tb_idx_reg_bank;
   logic        CLK = 1'b0, RES_N = 1'b0, sync = 1'b0;
   logic [11:0] pc = '0, pc_plus_one = '0;
   logic [3:0]  DATA_I = '0, opr_idx = '0, acc = '0;
   logic [7:0]  imm_pair = '0;
   logic        fim = 1'b0, fin = 1'b0, wr_alu = 1'b0, wr_acc = 1'b0, bank_we = 1'b0;
   logic [4:0]  alu_res = '0;
   logic [0:0]  bank_in = '0;
   logic [3:0]  rn, addr_o;
   logic [7:0]  rp;
   logic        rn_zero, addr_valid, fin_busy;
   logic [2:0]  phase;
   logic [0:0]  bank;

   idx_reg_bank dut (
      .CLK(CLK), .RES_N(RES_N), .sync(sync), .pc(pc), .pc_plus_one(pc_plus_one),
      .DATA_I(DATA_I), .opr_idx(opr_idx), .imm_pair(imm_pair), .fim(fim), .fin(fin),
      .wr_alu(wr_alu), .wr_acc(wr_acc), .alu_res(alu_res), .acc(acc), .bank_we(bank_we),
      .bank_in(bank_in), .rn(rn), .rp(rp), .rn_zero(rn_zero), .addr_o(addr_o),
      .addr_valid(addr_valid), .phase(phase), .fin_busy(fin_busy), .bank(bank)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] rn;
      logic [7:0] rp;
      logic       z;
      logic [3:0] a;
      logic       av;
      logic [2:0] ph;
      logic       busy;
      logic [0:0] bk;
   } exp_t;

   exp_t q[$];
   int checks = 0, failures = 0;

   // Reference state: registers kept per logical bank; indices >= 8 live only in bank 0.
   logic [3:0] m_r[2][16];
   int m_phase, m_fb, m_dst, m_bank;
   bit m_pend, m_act;

   function automatic logic [3:0] rd(input int b, input int i);
      return (i < 8) ? m_r[b][i] : m_r[0][i];
   endfunction

   task automatic wr(input int b, input int i, input logic [3:0] v);
      if (i < 8) m_r[b][i] = v;
      else       m_r[0][i] = v;
   endtask

   task automatic mreset();
      for (int b = 0; b < 2; b++) for (int i = 0; i < 16; i++) m_r[b][i] = '0;
      m_phase = 0; m_fb = 0; m_dst = 0; m_bank = 0; m_pend = 0; m_act = 0;
   endtask

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      checks++;
      if (a !== x) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", n, $time, a, x);
      end
   endtask

   // Called just after a rising edge with inputs applied; predicts, then advances one clock.
   task automatic tick();
      exp_t e;
      int ie, io;
      bit busy, ld_e, ld_o;
      if (!RES_N) mreset();
      ie = int'(opr_idx) & ~1;
      io = int'(opr_idx) | 1;
      e.rn = rd(m_bank, int'(opr_idx));
      e.rp = {rd(m_bank, ie), rd(m_bank, io)};
      e.z  = (e.rn == 4'd0);
      e.ph = 3'(m_phase);
      e.busy = m_pend | m_act;
      e.bk = 1'(m_bank);
      e.av = (m_phase < 3);
      e.a  = '0;
      if (m_phase < 3) begin
         if (!m_act)            e.a = 4'(pc >> (4 * m_phase));
         else if (m_phase == 0) e.a = rd(m_fb, 1);
         else if (m_phase == 1) e.a = rd(m_fb, 0);
         else                   e.a = 4'(pc_plus_one >> (4 * m_phase));
      end
      q.push_back(e);
      @(posedge CLK);
      if (!RES_N) mreset();
      else begin
         busy = m_pend | m_act;
         ld_e = m_act && m_phase == 3;
         ld_o = m_act && m_phase == 4;
         if (fim) begin
            wr(m_bank, ie, imm_pair[7:4]);
            wr(m_bank, io, imm_pair[3:0]);
         end
         else if (ld_e)   wr(m_fb, m_dst, DATA_I);
         else if (ld_o)   wr(m_fb, m_dst + 1, DATA_I);
         else if (wr_alu) wr(m_bank, int'(opr_idx), alu_res[3:0]);
         else if (wr_acc) wr(m_bank, int'(opr_idx), acc);
         if (ld_o) m_act = 0;
         if (sync && m_pend) begin m_act = 1; m_pend = 0; end
         if (fin && !busy) begin m_pend = 1; m_dst = ie; m_fb = m_bank; end
         if (bank_we && int'(bank_in) < 2) m_bank = int'(bank_in);
         m_phase = sync ? 0 : (m_phase + 1) % 8;
      end
      #1;
   endtask

   task automatic idle();
      sync = 0; fim = 0; fin = 0; wr_alu = 0; wr_acc = 0; bank_we = 0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rn",         32'(rn),         32'(e.rn));
            chk("rp",         32'(rp),         32'(e.rp));
            chk("rn_zero",    32'(rn_zero),    32'(e.z));
            chk("addr_o",     32'(addr_o),     32'(e.a));
            chk("addr_valid", 32'(addr_valid), 32'(e.av));
            chk("phase",      32'(phase),      32'(e.ph));
            chk("fin_busy",   32'(fin_busy),   32'(e.busy));
            chk("bank",       32'(bank),       32'(e.bk));
         end
      end
   end

   initial begin : driver
      mreset();
      @(posedge CLK); #1;
      run(2);
      RES_N = 1; pc = 12'h5A3;
      sync = 1; tick(); idle(); run(8);
      // FIM pair load, then fim racing wr_acc on the same register
      opr_idx = 2; imm_pair = 8'h7C; fim = 1; tick(); idle();
      opr_idx = 3; tick();
      fim = 1; wr_acc = 1; acc = 4'h5; tick(); idle(); tick();
      // FIN: pointer R0R1=0x4B, destination pair 6/7
      opr_idx = 0; imm_pair = 8'h4B; fim = 1; tick(); idle();
      pc_plus_one = 12'h9D1; opr_idx = 6; fin = 1; tick(); idle();
      sync = 1; tick(); idle(); run(3);
      DATA_I = 4'hE; tick(); DATA_I = 4'h2; tick(); run(3);
      opr_idx = 7; tick();
      // Bank switching: R3 banked, R12 shared
      bank_we = 1; bank_in = 1; tick(); idle();
      opr_idx = 3; wr_acc = 1; acc = 4'h5; tick(); idle(); tick();
      bank_we = 1; bank_in = 0; tick(); idle(); tick();
      bank_we = 1; bank_in = 1; tick(); idle();
      opr_idx = 12; wr_alu = 1; alu_res = 5'h19; tick(); idle();
      bank_we = 1; bank_in = 0; tick(); idle(); tick();
      // Second fin while busy is ignored; sync at phase 1 restarts the FIN
      opr_idx = 4; fin = 1; tick(); opr_idx = 8; tick(); idle();
      sync = 1; tick(); idle(); tick();
      sync = 1; tick(); idle();
      for (int i = 0; i < 8; i++) begin DATA_I = 4'(i + 3); tick(); end
      opr_idx = 5; tick();
      // Reset asserted during M1 of a FIN
      opr_idx = 10; fin = 1; tick(); idle();
      sync = 1; tick(); idle(); run(3);
      RES_N = 0; DATA_I = 4'hF;
      for (int i = 0; i < 16; i++) begin opr_idx = 4'(i); tick(); end
      RES_N = 1; run(2);
      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         sync        = (c % 8 == 0) ? 1'b1 : ($urandom_range(0, 19) == 0);
         fim         = ($urandom_range(0, 9) == 0);
         fin         = ($urandom_range(0, 5) == 0);
         wr_alu      = ($urandom_range(0, 5) == 0);
         wr_acc      = ($urandom_range(0, 5) == 0);
         bank_we     = ($urandom_range(0, 15) == 0);
         bank_in     = 1'($urandom);
         opr_idx     = 4'($urandom);
         imm_pair    = 8'($urandom);
         alu_res     = 5'($urandom);
         acc         = 4'($urandom);
         DATA_I      = 4'($urandom);
         pc          = 12'($urandom);
         pc_plus_one = 12'($urandom);
         tick();
      end
      idle(); run(2);
      @(negedge CLK); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
